// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the msrv32 fetch front end.
//   FETCH_* : 2-bit state codes of the fetch/flush sequencer
//   NOP_INSTR_C : canonical NOP (addi x0,x0,0) shown to decode during bubbles
//   FLUSH_CNT_W : width of the bubble counter (supports up to 7 bubbles)
// ---------------------------------------------------------------------------
package msrv32_pkg;

  localparam int          FLUSH_CNT_W = 3;
  localparam logic [31:0] NOP_INSTR_C = 32'h00000013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_RUN      = 2'd0;
  localparam fetch_state_t FETCH_HOLD     = 2'd1;
  localparam fetch_state_t FETCH_WAIT_MEM = 2'd2;
  localparam fetch_state_t FETCH_FLUSH    = 2'd3;

endpackage

// File: rtl/msrv32_fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// msrv32_fetch_hold_buf
// 32-bit instruction hold buffer with synchronous clear-to-NOP, load enable
// and an output select between the buffered word and the live memory word.
// Ports:
//   i_clk      : clock, rising edge
//   i_clear    : load NOP_INSTR into the buffer (wins over i_load)
//   i_load     : capture i_instr into the buffer
//   i_instr    : live instruction word from memory
//   i_sel_buf  : 1 = present buffered word, 0 = present live word
//   o_instr    : selected instruction word
// ---------------------------------------------------------------------------
module msrv32_fetch_hold_buf
  import msrv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic        i_sel_buf,
  output logic [31:0] o_instr
);

  logic [31:0] r_buf;

  // Clear has priority so a flush or reset always discards a pending capture.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_buf <= NOP_INSTR;
    end else if (i_load) begin
      r_buf <= i_instr;
    end
  end

  assign o_instr = i_sel_buf ? r_buf : i_instr;

endmodule

// File: rtl/msrv32_fetch_flush_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_fetch_flush_ctrl
// Fetch-side sequencer: produces the flush request, a stable instruction word
// and the PC-hold signal, absorbing memory wait states, downstream stalls and
// control-flow redirects / traps. Decode sees NOP_INSTR while flushing.
// Ports:
//   ms_riscv32_mp_clk_in          : clock, rising edge
//   ms_riscv32_mp_rst_in          : synchronous active-high reset
//   ms_riscv32_mp_instr_hready_in : instruction memory data valid
//   ms_riscv32_mp_instr_in        : instruction word from memory
//   redirect_in                   : taken branch / jump redirect
//   trap_taken_in                 : trap or mret taken
//   stall_in                      : downstream cannot accept this cycle
//   flush_out                     : flush request to the instruction mux
//   instr_out                     : instruction word to the instruction mux
//   pc_hold_out                   : PC mux keeps the current PC
//   instr_valid_out               : instr_out is a consumable instruction
// Optional (macro MSRV32_FETCH_PERF_CNT_EN):
//   bubble_cnt_out                : cycles with flush_out=1 (wrapping)
//   stall_cnt_out                 : cycles in HOLD with stall_in=1 (wrapping)
// ---------------------------------------------------------------------------
module msrv32_fetch_flush_ctrl
  import msrv32_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ms_riscv32_mp_instr_hready_in,
  input  logic [31:0] ms_riscv32_mp_instr_in,
  input  logic        redirect_in,
  input  logic        trap_taken_in,
  input  logic        stall_in,
  output logic        flush_out,
  output logic [31:0] instr_out,
  output logic        pc_hold_out,
  output logic        instr_valid_out
`ifdef MSRV32_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt_out,
  output logic [31:0] stall_cnt_out
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CYCLES[FLUSH_CNT_W-1:0];

  fetch_state_t           r_state;
  logic [FLUSH_CNT_W-1:0] r_flushCnt;

  fetch_state_t           w_stateNxt;
  logic [FLUSH_CNT_W-1:0] w_cntNxt;
  logic                   w_flushEvt;
  logic                   w_bufLoad;
  logic                   w_bufClear;
  logic                   w_selBuf;
  logic [31:0]            w_bufInstr;

  assign w_flushEvt = trap_taken_in | redirect_in;

  // Next-state and output decode. A redirect or trap overrides everything
  // except reset; RUN and WAIT_MEM share the same handling because a
  // WAIT_MEM cycle with hready=1 behaves exactly like a RUN cycle.
  always_comb begin
    w_stateNxt      = r_state;
    w_cntNxt        = r_flushCnt;
    w_bufLoad       = 1'b0;
    w_bufClear      = 1'b0;
    w_selBuf        = 1'b0;
    flush_out       = 1'b0;
    instr_valid_out = 1'b0;
    pc_hold_out     = 1'b0;
    if (w_flushEvt) begin
      flush_out  = 1'b1;
      w_stateNxt = FETCH_FLUSH;
      w_cntNxt   = FLUSH_LOAD;
      w_bufClear = 1'b1;
    end else begin
      case (r_state)
        FETCH_FLUSH: begin
          flush_out = 1'b1;
          // A stall freezes the bubble count; the last bubble picks the exit
          // state from the memory handshake seen in that cycle.
          if (!stall_in) begin
            if (r_flushCnt <= 1) begin
              w_stateNxt = ms_riscv32_mp_instr_hready_in ? FETCH_RUN : FETCH_WAIT_MEM;
            end else begin
              w_cntNxt = r_flushCnt - 1'b1;
            end
          end
        end
        FETCH_RUN, FETCH_WAIT_MEM: begin
          if (ms_riscv32_mp_instr_hready_in) begin
            instr_valid_out = 1'b1;
            pc_hold_out     = stall_in;
            if (stall_in) begin
              w_bufLoad  = 1'b1;
              w_stateNxt = FETCH_HOLD;
            end else begin
              w_stateNxt = FETCH_RUN;
            end
          end else begin
            flush_out   = 1'b1;
            pc_hold_out = 1'b1;
            w_stateNxt  = FETCH_WAIT_MEM;
          end
        end
        FETCH_HOLD: begin
          w_selBuf        = 1'b1;
          instr_valid_out = 1'b1;
          pc_hold_out     = stall_in;
          if (!stall_in) begin
            w_stateNxt = FETCH_RUN;
          end
        end
        default: begin
          flush_out  = 1'b1;
          w_stateNxt = FETCH_FLUSH;
          w_cntNxt   = FLUSH_LOAD;
          w_bufClear = 1'b1;
        end
      endcase
    end
  end

  // Any bubble shows the NOP word regardless of what memory is returning.
  assign instr_out = flush_out ? NOP_INSTR : w_bufInstr;

  // State and bubble counter; reset lands in FLUSH with a full count.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state    <= FETCH_FLUSH;
      r_flushCnt <= FLUSH_LOAD;
    end else begin
      r_state    <= w_stateNxt;
      r_flushCnt <= w_cntNxt;
    end
  end

  msrv32_fetch_hold_buf #(
    .NOP_INSTR (NOP_INSTR)
  ) u_hold_buf (
    .i_clk     (ms_riscv32_mp_clk_in),
    .i_clear   (ms_riscv32_mp_rst_in | w_bufClear),
    .i_load    (w_bufLoad),
    .i_instr   (ms_riscv32_mp_instr_in),
    .i_sel_buf (w_selBuf),
    .o_instr   (w_bufInstr)
  );

`ifdef MSRV32_FETCH_PERF_CNT_EN
  logic [31:0] r_bubbleCnt;
  logic [31:0] r_stallCnt;

  // Free-running event counters; natural 32-bit wrap.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_bubbleCnt <= '0;
      r_stallCnt  <= '0;
    end else begin
      if (flush_out) begin
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
      end
      if ((r_state == FETCH_HOLD) && stall_in) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end

  assign bubble_cnt_out = r_bubbleCnt;
  assign stall_cnt_out  = r_stallCnt;
`endif

endmodule

// File: tb/tb_msrv32_fetch_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msrv32_fetch_flush_ctrl
// Drives two instances (FLUSH_CYCLES=1 and FLUSH_CYCLES=3) with the same
// directed and random stimulus and compares every output against a
// behavioural model built from the fetch rules: remaining bubbles, an
// optional held word, otherwise live passthrough gated by hready.
// Optional macro MSRV32_FETCH_PERF_CNT_EN also checks the perf counters.
// ---------------------------------------------------------------------------
module tb_msrv32_fetch_flush_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        hready;
  logic [31:0] instrIn;
  logic        redirect;
  logic        trap;
  logic        stall;

  logic        flushO [2];
  logic [31:0] instrO [2];
  logic        holdO  [2];
  logic        validO [2];
`ifdef MSRV32_FETCH_PERF_CNT_EN
  logic [31:0] bubO   [2];
  logic [31:0] stlO   [2];
`endif

  int          checks   = 0;
  int          failures = 0;

  int          fc        [2] = '{1, 3};
  bit          mValid    [2];
  int          mBubbles  [2];
  bit          mHeld     [2];
  logic [31:0] mHeldWord [2];
  logic [31:0] mBub      [2];
  logic [31:0] mStl      [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  msrv32_fetch_flush_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst),
    .ms_riscv32_mp_instr_hready_in (hready),
    .ms_riscv32_mp_instr_in        (instrIn),
    .redirect_in                   (redirect),
    .trap_taken_in                 (trap),
    .stall_in                      (stall),
    .flush_out                     (flushO[0]),
    .instr_out                     (instrO[0]),
    .pc_hold_out                   (holdO[0]),
    .instr_valid_out               (validO[0])
`ifdef MSRV32_FETCH_PERF_CNT_EN
    ,
    .bubble_cnt_out                (bubO[0]),
    .stall_cnt_out                 (stlO[0])
`endif
  );

  msrv32_fetch_flush_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst),
    .ms_riscv32_mp_instr_hready_in (hready),
    .ms_riscv32_mp_instr_in        (instrIn),
    .redirect_in                   (redirect),
    .trap_taken_in                 (trap),
    .stall_in                      (stall),
    .flush_out                     (flushO[1]),
    .instr_out                     (instrO[1]),
    .pc_hold_out                   (holdO[1]),
    .instr_valid_out               (validO[1])
`ifdef MSRV32_FETCH_PERF_CNT_EN
    ,
    .bubble_cnt_out                (bubO[1]),
    .stall_cnt_out                 (stlO[1])
`endif
  );

  // Expected outputs for instance k given the current inputs.
  task automatic modelOutputs(input int k, output logic ef, output logic ev,
                              output logic eh, output logic [31:0] ei);
    if (trap || redirect || (mBubbles[k] > 0)) begin
      ef = 1'b1; ev = 1'b0; eh = 1'b0; ei = NOP;
    end else if (mHeld[k]) begin
      ef = 1'b0; ev = 1'b1; eh = stall; ei = mHeldWord[k];
    end else if (hready) begin
      ef = 1'b0; ev = 1'b1; eh = stall; ei = instrIn;
    end else begin
      ef = 1'b1; ev = 1'b0; eh = 1'b1; ei = NOP;
    end
  endtask

  // Advance the model across one rising edge.
  task automatic modelStep(input int k);
    logic ef, ev, eh;
    logic [31:0] ei;
    if (rst) begin
      mValid[k]   = 1'b1;
      mBubbles[k] = fc[k];
      mHeld[k]    = 1'b0;
      mBub[k]     = 32'd0;
      mStl[k]     = 32'd0;
    end else if (mValid[k]) begin
      modelOutputs(k, ef, ev, eh, ei);
      mBub[k] = mBub[k] + {31'd0, ef};
      mStl[k] = mStl[k] + {31'd0, (mHeld[k] && mBubbles[k] == 0 && stall)};
      if (trap || redirect) begin
        mBubbles[k] = fc[k];
        mHeld[k]    = 1'b0;
      end else if (mBubbles[k] > 0) begin
        if (!stall) mBubbles[k] = mBubbles[k] - 1;
      end else if (mHeld[k]) begin
        if (!stall) mHeld[k] = 1'b0;
      end else if (hready && stall) begin
        mHeld[k]     = 1'b1;
        mHeldWord[k] = instrIn;
      end
    end
  endtask

  task automatic checkOne(input string tag, input int k,
                          input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s (FLUSH_CYCLES=%0d) observed=%h expected=%h", tag, fc[k], obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic ef, ev, eh;
    logic [31:0] ei;
    for (int k = 0; k < 2; k++) begin
      if (mValid[k]) begin
        modelOutputs(k, ef, ev, eh, ei);
        checkOne("flush_out", k, {31'd0, flushO[k]}, {31'd0, ef});
        checkOne("instr_valid_out", k, {31'd0, validO[k]}, {31'd0, ev});
        checkOne("pc_hold_out", k, {31'd0, holdO[k]}, {31'd0, eh});
        checkOne("instr_out", k, instrO[k], ei);
`ifdef MSRV32_FETCH_PERF_CNT_EN
        checkOne("bubble_cnt_out", k, bubO[k], mBub[k]);
        checkOne("stall_cnt_out", k, stlO[k], mStl[k]);
`endif
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, check mid-phase, then
  // advance the model on the rising edge.
  task automatic applyStimulus(input logic r, input logic hr, input logic [31:0] ins,
                               input logic rd, input logic tr, input logic st);
    rst = r; hready = hr; instrIn = ins; redirect = rd; trap = tr; stall = st;
    #1;
    checkOutput();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; hready = 1'b1; instrIn = NOP; redirect = 1'b0; trap = 1'b0; stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mValid[k] = 1'b0; mBubbles[k] = 0; mHeld[k] = 1'b0;
      mHeldWord[k] = NOP; mBub[k] = 32'd0; mStl[k] = 32'd0;
    end
    @(negedge clk);

    // Reset for two cycles, then release with memory ready.
    applyStimulus(1, 1, 32'h00500093, 0, 0, 0);
    applyStimulus(1, 1, 32'h00500093, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h00500093, 0, 0, 0);

    // Stall for three cycles with the memory word changing underneath.
    applyStimulus(0, 1, 32'h00208133, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 0, 0);
    applyStimulus(0, 1, 32'h00308193, 0, 0, 0);

    // Two memory wait states, then resume.
    applyStimulus(0, 0, $urandom, 0, 0, 0);
    applyStimulus(0, 0, $urandom, 0, 0, 0);
    applyStimulus(0, 1, 32'h00410213, 0, 0, 0);
    applyStimulus(0, 1, 32'h00518293, 0, 0, 0);

    // Redirect while holding a stalled word.
    applyStimulus(0, 1, 32'h00620313, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h00728393, 0, 0, 0);

    // Trap with redirect, then stalls that freeze the bubble count.
    applyStimulus(0, 1, $urandom, 1, 1, 0);
    applyStimulus(0, 1, $urandom, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h00830413, 0, 0, 0);

    // Redirect together with a stall in RUN, and reset mid-HOLD.
    applyStimulus(0, 1, $urandom, 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h00938493, 0, 0, 0);
    applyStimulus(0, 1, 32'h00a40513, 0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 0, 1);
    applyStimulus(1, 1, $urandom, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, $urandom, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, $urandom, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0),
                    $urandom,
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) == 0));
    end

    // Final reset: everything, including counters, returns to initial values.
    applyStimulus(1, 1, $urandom, 0, 0, 0);
    applyStimulus(0, 1, $urandom, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
